// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a synchronous FIFO with a registered read port.
// Pops one byte per frame and shifts it out LSB first as 8N1/8E1.
module fifo_uart_tx #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [BW-1:0]         r_baud;
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_sh;
    logic                  r_parity;
    logic                  r_tx;
    logic                  w_tx_next;
    logic                  w_bit_end;
    logic                  w_last_data;
    logic                  w_last_stop;

    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign w_last_data = (r_bit_cnt == DATA_LAST);
    assign w_last_stop = (r_bit_cnt == STOP_LAST);
    assign w_shift_sh  = r_shift >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_next = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && w_last_data) begin
                    w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end && w_last_stop) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Counters and shifter; the baud counter is zero on entry to START.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            unique case (r_state)
                S_CAPTURE: begin
                    r_shift   <= fifo_dout;
                    r_parity  <= ^fifo_dout;
                    r_bit_cnt <= '0;
                    r_baud    <= '0;
                end
                S_START, S_PARITY: begin
                    r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
                end
                S_DATA: begin
                    r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
                    if (w_bit_end) begin
                        r_shift   <= w_shift_sh;
                        r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
                    if (w_bit_end) begin
                        r_bit_cnt <= w_last_stop ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_baud    <= '0;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    // Line level is computed for the upcoming cycle so tx is a plain flop.
    always_comb begin
        w_tx_next = 1'b1;
        unique case (w_state_next)
            S_START: begin
                w_tx_next = 1'b0;
            end
            S_DATA: begin
                if (r_state == S_DATA && w_bit_end) begin
                    w_tx_next = w_shift_sh[0];
                end else begin
                    w_tx_next = r_shift[0];
                end
            end
            S_PARITY: begin
                w_tx_next = r_parity;
            end
            default: begin
                w_tx_next = 1'b1;
            end
        endcase
    end

    always_comb begin
        fifo_rd_en = (r_state == S_FETCH);
        busy       = (r_state != S_IDLE);
        tx_done    = (r_state == S_STOP) && w_bit_end && w_last_stop;
        tx         = r_tx;
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (8N1 and 8E2) fed by queue FIFOs,
// frames compared against a per-cycle line-level model.
module tb_fifo_uart_tx;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] tx_en = 2'b11;
    logic [1:0] fifo_empty = 2'b11;
    logic [7:0] fifo_dout [2];
    logic [1:0] rd_en;
    logic [1:0] tx;
    logic [1:0] busy;
    logic [1:0] done;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] p0 [$];
    logic [7:0] p1 [$];
    logic       rd_s0 = 1'b0;
    logic       rd_s1 = 1'b0;
    int         pops0 = 0;
    int         pops1 = 0;
    int         viol = 0;

    int errs = 0;
    int checks = 0;
    int gap;
    int n;
    int bad;
    int base;
    int xb;
    int rb;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLK_DIV(CD), .DATA_WIDTH(8), .PARITY_EN(0), .STOP_BITS(1)
    ) u_dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en[0]),
        .fifo_empty(fifo_empty[0]), .fifo_dout(fifo_dout[0]),
        .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]),
        .tx_done(done[0])
    );

    fifo_uart_tx #(
        .CLK_DIV(CD), .DATA_WIDTH(8), .PARITY_EN(1), .STOP_BITS(2)
    ) u_dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en[1]),
        .fifo_empty(fifo_empty[1]), .fifo_dout(fifo_dout[1]),
        .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]),
        .tx_done(done[1])
    );

    // FIFO models: pop strobe sampled mid-cycle, outputs update on the edge.
    always @(negedge clk) begin
        rd_s0 = rd_en[0];
        rd_s1 = rd_en[1];
    end

    always @(posedge clk) begin
        if (rd_s0) begin
            if (q0.size() > 0) begin
                fifo_dout[0] <= q0.pop_front();
                pops0++;
            end else begin
                viol++;
            end
        end
        if (rd_s1) begin
            if (q1.size() > 0) begin
                fifo_dout[1] <= q1.pop_front();
                pops1++;
            end else begin
                viol++;
            end
        end
        while (p0.size() > 0) q0.push_back(p0.pop_front());
        while (p1.size() > 0) q1.push_back(p1.pop_front());
        fifo_empty[0] <= (q0.size() == 0);
        fifo_empty[1] <= (q1.size() == 0);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int d, input int b);
        if (d == 0) p0.push_back(b[7:0]);
        else        p1.push_back(b[7:0]);
    endtask

    function automatic int pops(input int d);
        return (d == 0) ? pops0 : pops1;
    endfunction

    // Expected line level i cycles after the start-bit edge.
    function automatic int level(input int b, input int p, input int i);
        logic [7:0] bb;
        int k;
        bb = b[7:0];
        k = i / CD;
        if (k == 0) return 0;
        if (k <= 8) return int'(bb[k-1]);
        if (p != 0 && k == 9) return int'(^bb);
        return 1;
    endfunction

    task automatic rx_frame(input int d, input int p, input int s,
                            input int exp_b, output int g);
        int flen, fbad, got, par, dpos, dcnt, k;
        logic e;
        logic [7:0] eb;
        flen = (1 + 8 + p + s) * CD;
        eb = exp_b[7:0];
        g = 0;
        forever begin
            @(negedge clk);
            if (tx[d] === 1'b0 || g >= 300) break;
            g++;
        end
        check("start_seen", int'(tx[d] === 1'b0), 1);
        if (tx[d] !== 1'b0) return;
        fbad = 0; got = 0; par = 0; dpos = 0; dcnt = 0;
        for (int i = 0; i < flen; i++) begin
            if (i > 0) @(negedge clk);
            e = (level(exp_b, p, i) != 0);
            if (tx[d] !== e) fbad++;
            if (busy[d] !== 1'b1) fbad++;
            if (i % CD == CD / 2) begin
                k = i / CD;
                if (k >= 1 && k <= 8) got |= int'(tx[d]) << (k - 1);
                if (p != 0 && k == 9) par = int'(tx[d]);
            end
            if (done[d] === 1'b1) begin
                dcnt++;
                dpos = i + 1;
            end
        end
        check("wave", fbad, 0);
        check("byte", got, exp_b);
        if (p != 0) check("parity", par, int'(^eb));
        check("done_cnt", dcnt, 1);
        check("done_pos", dpos, flen);
    endtask

    initial begin
        fifo_dout[0] = 8'h00;
        fifo_dout[1] = 8'h00;

        // Reset held with the FIFO non-empty
        push(0, 8'h55);
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", int'(tx[0]), 1);
            check("rst_rd", int'(rd_en[0]), 0);
            check("rst_busy", int'(busy[0]), 0);
        end
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rd_en[0] !== 1'b1 && n < 20);
        check("rst_lat", n, 1);

        // Single byte 0x55
        rx_frame(0, 0, 1, 8'h55, gap);
        check("start_lat", gap, 1);
        check("pops_single", pops0, 1);
        @(negedge clk);
        check("busy_fall", int'(busy[0]), 0);

        // Back-to-back frames
        base = pops0;
        push(0, 8'hA3);
        push(0, 8'h0F);
        push(0, 8'hFF);
        rx_frame(0, 0, 1, 8'hA3, gap);
        rx_frame(0, 0, 1, 8'h0F, gap);
        check("gap12", gap, 3);
        rx_frame(0, 0, 1, 8'hFF, gap);
        check("gap23", gap, 3);
        check("pops_b2b", pops0 - base, 3);
        check("empty_b2b", int'(fifo_empty[0]), 1);

        // Parity + two stop bits, then random bytes
        push(1, 8'h07);
        push(1, 8'h03);
        rx_frame(1, 1, 2, 8'h07, gap);
        rx_frame(1, 1, 2, 8'h03, gap);
        check("gap_par", gap, 3);
        for (int j = 0; j < 4; j++) begin
            rb = int'($urandom_range(0, 255));
            push(1, rb);
            rx_frame(1, 1, 2, rb, gap);
        end

        // Flow control
        tx_en[0] = 1'b0;
        base = pops0;
        xb = int'($urandom_range(0, 255));
        rb = int'($urandom_range(0, 255));
        push(0, xb);
        push(0, rb);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        check("hold_line", bad, 0);
        check("hold_pops", pops0 - base, 0);
        tx_en[0] = 1'b1;
        fork
            rx_frame(0, 0, 1, xb, gap);
            begin
                repeat (20) @(negedge clk);
                tx_en[0] = 1'b0;
            end
        join
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        check("fc_stopped", bad, 0);
        check("fc_pops", pops0 - base, 1);
        check("fc_left", q0.size(), 1);
        tx_en[0] = 1'b1;
        rx_frame(0, 0, 1, rb, gap);

        // Reset during data bit 3 of 0xC6
        xb = int'($urandom_range(0, 255));
        if (xb == 8'hC6) xb = 8'h39;
        push(0, 8'hC6);
        push(0, xb);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx[0] !== 1'b0 && n < 50);
        check("mid_start", int'(tx[0]), 0);
        repeat (4 * CD + 1) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_tx", int'(tx[0]), 1);
        check("mid_busy", int'(busy[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        check("mid_left", q0.size(), 1);
        rx_frame(0, 0, 1, xb, gap);

        check("no_underflow", viol, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
